priority_encoder8_3: RTL and testbench

Sequential 8-to-3 priority encoder, the encode-side counterpart of the team's 3-to-8 decoder. It accepts an 8-bit request vector through a valid/ready handshake and holds it internally. It then emits the 3-bit index of every set bit, lowest index first, one index per accepted output handshake. Upstream request collectors feed it, and the emitted codes drive the 3-to-8 decoder or any index-based consumer.

---
 rtl/priority_encoder8_3_if.sv | 23 ++
 rtl/priority_encoder8_3.sv | 78 +++++++
 tb/tb_priority_encoder8_3.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/priority_encoder8_3_if.sv
// Request/code handshake bundle between a request collector, the 8-to-3
// priority encoder and the index consumer.
interface priority_encoder8_3_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_vec;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_code;
    logic       out_last;
    logic       zero_err;
    logic       busy;

    modport slave (
        input  in_valid, in_vec, out_ready,
        output in_ready, out_valid, out_code, out_last, zero_err, busy
    );

    modport master (
        output in_valid, in_vec, out_ready,
        input  in_ready, out_valid, out_code, out_last, zero_err, busy
    );
endinterface

// File: rtl/priority_encoder8_3.sv
// Sequential 8-to-3 priority encoder: latches a request vector, then emits the
// index of each set bit, lowest first, one per output handshake.
module priority_encoder8_3 (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    priority_encoder8_3_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, SERVE = 1'b1} state_t;

    state_t     state_q, state_d;
    logic [7:0] pending_q, pending_d;
    logic       zero_err_q, zero_err_d;
    logic [2:0] low_idx;
    logic       single_bit;
    logic       in_fire;
    logic       out_fire;

    function automatic logic [2:0] lowest_set(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    function automatic logic is_single(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

    assign low_idx    = lowest_set(pending_q);
    assign single_bit = is_single(pending_q);

    // Handshake strobes depend only on state and en, never on the data inputs.
    assign bus.in_ready  = en && (state_q == IDLE);
    assign bus.out_valid = en && (state_q == SERVE);
    assign bus.out_code  = bus.out_valid ? low_idx : 3'd0;
    assign bus.out_last  = bus.out_valid && single_bit;
    assign bus.busy      = (state_q == SERVE);
    assign bus.zero_err  = zero_err_q;

    assign in_fire  = bus.in_valid && bus.in_ready;
    assign out_fire = bus.out_valid && bus.out_ready;

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        zero_err_d = 1'b0;
        if (in_fire) begin
            if (bus.in_vec != 8'd0) begin
                pending_d = bus.in_vec;
                state_d   = SERVE;
            end else begin
                zero_err_d = 1'b1;
            end
        end else if (out_fire) begin
            if (single_bit) begin
                pending_d = 8'd0;
                state_d   = IDLE;
            end else begin
                pending_d = pending_q & ~(8'd1 << low_idx);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pending_q  <= 8'd0;
            zero_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            zero_err_q <= zero_err_d;
        end
    end
endmodule

// File: tb/tb_priority_encoder8_3.sv
// Scoreboard bench for priority_encoder8_3: expected codes are queued when a
// vector is offered and compared whenever the encoder presents a code.
module tb_priority_encoder8_3;
    logic clk;
    logic rst;
    logic en;
    int   n_chk;
    int   n_fail;

    logic [3:0] exp_q[$];   // {last, code}

    priority_encoder8_3_if bus ();

    priority_encoder8_3 dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_expected(input logic [7:0] vec);
        logic [7:0] rest;
        for (int k = 0; k < 8; k++) begin
            if (vec[k]) begin
                rest = vec >> (k + 1);
                exp_q.push_back({(rest == 8'd0), 3'(k)});
            end
        end
    endtask

    // Offers vec for one edge; returns just after the accepting edge.
    task automatic load(input logic [7:0] vec);
        bus.in_vec   = vec;
        bus.in_valid = 1'b1;
        @(negedge clk);
        chk("load_in_ready", {7'd0, bus.in_ready}, 8'd1);
        push_expected(vec);
        step();
        bus.in_valid = 1'b0;
        bus.in_vec   = $urandom_range(0, 255);
    endtask

    task automatic wait_idle(input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) done = 1'b1;
        end
        if (!done) chk("wait_idle_timeout", 8'd0, 8'd1);
        step();
        @(negedge clk);
        chk("idle_in_ready", {7'd0, bus.in_ready}, 8'd1);
        chk("idle_busy", {7'd0, bus.busy}, 8'd0);
        step();
    endtask

    // Scoreboard monitor: every presented code must match the queue head.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_valid", 8'd1, 8'd0);
                end else begin
                    chk("sb_code", {5'd0, bus.out_code}, {5'd0, exp_q[0][2:0]});
                    chk("sb_last", {7'd0, bus.out_last}, {7'd0, exp_q[0][3]});
                    if (bus.out_ready) void'(exp_q.pop_front());
                end
            end else begin
                chk("idle_code", {4'd0, bus.out_last, bus.out_code}, 8'd0);
            end
        end
    end

    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst = 1'b1;
        en = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_vec = 8'd0;
        bus.out_ready = 1'b0;

        #12;
        chk("rst_in_ready", {7'd0, bus.in_ready}, 8'd1);
        chk("rst_out_valid", {7'd0, bus.out_valid}, 8'd0);
        chk("rst_busy", {7'd0, bus.busy}, 8'd0);
        chk("rst_zero_err", {7'd0, bus.zero_err}, 8'd0);
        #1 rst = 1'b0;
        step();

        // Reset while serving 8'b10100000.
        bus.out_ready = 1'b0;
        load(8'b1010_0000);
        @(negedge clk);
        chk("pre_rst_busy", {7'd0, bus.busy}, 8'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", {7'd0, bus.out_valid}, 8'd0);
        chk("mid_rst_out_code", {5'd0, bus.out_code}, 8'd0);
        chk("mid_rst_busy", {7'd0, bus.busy}, 8'd0);
        chk("mid_rst_in_ready", {7'd0, bus.in_ready}, 8'd1);
        exp_q.delete();
        @(negedge clk);
        #3 rst = 1'b0;
        step();

        // Single bit.
        bus.out_ready = 1'b1;
        load(8'b0010_0000);
        @(negedge clk);
        chk("single_out_valid", {7'd0, bus.out_valid}, 8'd1);
        step();
        @(negedge clk);
        chk("single_back_idle", {7'd0, bus.in_ready}, 8'd1);
        chk("single_queue_empty", 8'(exp_q.size()), 8'd0);
        step();

        // Multi-bit order 1, 4, 7.
        load(8'b1001_0010);
        wait_idle(20);

        // Backpressure on 8'hFF.
        load(8'hFF);
        for (int i = 0; i < 64 && exp_q.size() != 0; i++) begin
            bus.out_ready = pat[i % 4];
            @(negedge clk);
            if (exp_q.size() != 0) chk("bp_in_ready", {7'd0, bus.in_ready}, 8'd0);
            step();
        end
        chk("bp_drained", 8'(exp_q.size()), 8'd0);
        bus.out_ready = 1'b1;
        wait_idle(4);

        // Zero vector then single bit 0.
        load(8'h00);
        @(negedge clk);
        chk("zero_err_pulse", {7'd0, bus.zero_err}, 8'd1);
        chk("zero_out_valid", {7'd0, bus.out_valid}, 8'd0);
        chk("zero_in_ready", {7'd0, bus.in_ready}, 8'd1);
        step();
        @(negedge clk);
        chk("zero_err_cleared", {7'd0, bus.zero_err}, 8'd0);
        step();
        load(8'h01);
        wait_idle(10);

        // Enable freeze after code 2.
        load(8'b0000_1100);
        step();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("freeze_out_valid", {7'd0, bus.out_valid}, 8'd0);
            chk("freeze_in_ready", {7'd0, bus.in_ready}, 8'd0);
            chk("freeze_busy", {7'd0, bus.busy}, 8'd1);
            chk("freeze_pending_left", 8'(exp_q.size()), 8'd1);
            step();
        end
        en = 1'b1;
        wait_idle(10);

        chk("final_queue_empty", 8'(exp_q.size()), 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
